// File: rtl/cs_result_checker.sv
// cs_result_checker: on-chip golden-compare for the CS median/approximation `y` stream.
// After `start` the first WARMUP samples of `y` are discarded while the CS window fills.
// The next N_CMP samples are compared in lockstep against words from a synchronous
// golden memory that has a read latency of one cycle.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   start          one-cycle run request, honoured in IDLE or DONE only
//   y              10-bit CS output sample
//   gold_rd        golden read strobe (high for the N_CMP RUN cycles)
//   gold_addr      golden index 0..N_CMP-1
//   gold_data      golden word, valid one cycle after gold_rd
//   mismatch       one-cycle pulse per failing compare
//   err_cnt        saturating count of failing compares
//   first_err_idx  index of the first failing compare, 0 if none
//   done           high in DONE
//   pass           high in DONE when no compare failed
module cs_result_checker #(
  parameter int unsigned WARMUP = 8,
  parameter int unsigned N_CMP  = 1992,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        y,
  output logic              gold_rd,
  output logic [ADDR_W-1:0] gold_addr,
  input  logic [9:0]        gold_data,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic              done,
  output logic              pass
);

  localparam int unsigned WarmW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WarmW-1:0]  WarmLast = WarmW'(WARMUP - 1);
  localparam logic [ADDR_W-1:0] IdxLast  = ADDR_W'(N_CMP - 1);

  typedef enum logic [2:0] {StIdle, StWarm, StRun, StDrain, StDone} state_e;

  state_e              state_q;
  logic [WarmW-1:0]    warm_cnt_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                gold_rd_q;
  // Compare-stage pipeline: sample and index aligned with the returning golden word.
  logic                cmp_v_q;
  logic [9:0]          y_dly_q;
  logic [ADDR_W-1:0]   idx_dly_q;
  logic                mismatch_q;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_err_q, first_err_d;
  logic                done_q;
  logic                pass_q;
  logic                cmp_fail;

  always_comb begin
    cmp_fail    = cmp_v_q && (gold_data != y_dly_q);
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    if (cmp_fail) begin
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
      // The counter saturates and never wraps, so zero means no earlier failure.
      if (err_cnt_q == '0) begin
        first_err_d = idx_dly_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      warm_cnt_q  <= '0;
      idx_q       <= '0;
      gold_rd_q   <= 1'b0;
      cmp_v_q     <= 1'b0;
      y_dly_q     <= '0;
      idx_dly_q   <= '0;
      mismatch_q  <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      cmp_v_q     <= gold_rd_q;
      if (gold_rd_q) begin
        y_dly_q   <= y;
        idx_dly_q <= idx_q;
      end
      mismatch_q  <= cmp_fail;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;

      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            err_cnt_q   <= '0;
            first_err_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            idx_q       <= '0;
            warm_cnt_q  <= '0;
            if (WARMUP == 0) begin
              state_q   <= StRun;
              gold_rd_q <= 1'b1;
            end else begin
              state_q   <= StWarm;
            end
          end
        end
        StWarm: begin
          if (warm_cnt_q == WarmLast) begin
            state_q   <= StRun;
            gold_rd_q <= 1'b1;
          end else begin
            warm_cnt_q <= warm_cnt_q + WarmW'(1);
          end
        end
        StRun: begin
          if (idx_q == IdxLast) begin
            state_q   <= StDrain;
            gold_rd_q <= 1'b0;
            idx_q     <= '0;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        StDrain: begin
          // The last compare resolves on this edge, so the verdict uses the next count.
          state_q <= StDone;
          done_q  <= 1'b1;
          pass_q  <= (err_cnt_d == '0);
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign gold_rd       = gold_rd_q;
  assign gold_addr     = idx_q;
  assign mismatch      = mismatch_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_q;
  assign done          = done_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_cs_result_checker.sv
// Self-checking bench for cs_result_checker with WARMUP=8, N_CMP=16, ERR_W=3.
// Each run builds a golden table and a sample table, then predicts every output
// cycle by cycle from the documented timing (edge numbers counted from E0).
module tb_cs_result_checker;

  localparam int W = 8;
  localparam int N = 16;
  localparam int ErrMax = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [9:0] y = '0;
  logic       gold_rd;
  logic [3:0] gold_addr;
  logic [9:0] gold_data = '0;
  logic       mismatch;
  logic [2:0] err_cnt;
  logic [3:0] first_err_idx;
  logic       done;
  logic       pass;

  int n_total = 0;
  int n_bad   = 0;

  logic [9:0] gold_mem [N];
  logic [9:0] ysamp    [N];

  cs_result_checker #(
    .WARMUP(W),
    .N_CMP (N),
    .ADDR_W(4),
    .ERR_W (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .y            (y),
    .gold_rd      (gold_rd),
    .gold_addr    (gold_addr),
    .gold_data    (gold_data),
    .mismatch     (mismatch),
    .err_cnt      (err_cnt),
    .first_err_idx(first_err_idx),
    .done         (done),
    .pass         (pass)
  );

  always #5 clk = ~clk;

  // Golden memory: synchronous read, one cycle latency.
  always @(posedge clk) begin
    if (gold_rd) gold_data <= gold_mem[gold_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rd"},    32'(gold_rd), 0);
    check_val({tag, "_addr"},  32'(gold_addr), 0);
    check_val({tag, "_mm"},    32'(mismatch), 0);
    check_val({tag, "_err"},   32'(err_cnt), 0);
    check_val({tag, "_first"}, 32'(first_err_idx), 0);
    check_val({tag, "_done"},  32'(done), 0);
    check_val({tag, "_pass"},  32'(pass), 0);
  endtask

  // mode 0: ramp equal, 1: ramp with 0x3FF at index 5, 2: all inverted,
  // 3: random with ~25% errors, 4: inverted from index 3 on.
  task automatic do_run(input int mode, input bit repulse, input bit abort);
    int fails;
    int cnt;
    int first;
    bit failed_any;
    for (int k = 0; k < N; k++) begin
      if (mode <= 1) gold_mem[k] = 10'(k);
      else gold_mem[k] = 10'($urandom);
      ysamp[k] = gold_mem[k];
      case (mode)
        1: if (k == 5) ysamp[k] = 10'h3FF;
        2: ysamp[k] = ~gold_mem[k];
        3: if ($urandom_range(3) == 0) ysamp[k] = gold_mem[k] ^ 10'(1 << $urandom_range(9));
        4: if (k >= 3) ysamp[k] = ~gold_mem[k];
        default: ;
      endcase
    end
    fails = 0;
    for (int k = 0; k < N; k++) if (ysamp[k] != gold_mem[k]) fails++;

    @(negedge clk);
    start = 1'b1;
    @(posedge clk); // E0
    for (int c = 0; c <= W + N + 3; c++) begin
      @(negedge clk); // cycle following edge E(c)
      // Compares for index k resolve on E(W+k+2).
      cnt = 0;
      first = 0;
      failed_any = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (ysamp[k] != gold_mem[k] && W + k + 2 <= c) begin
          if (!failed_any) first = k;
          failed_any = 1'b1;
          cnt++;
        end
      end
      check_val("gold_rd", 32'(gold_rd), 32'(c >= W && c < W + N));
      if (c >= W && c < W + N) check_val("gold_addr", 32'(gold_addr), 32'(c - W));
      if (c >= W + 2 && c < W + N + 2)
        check_val("mismatch", 32'(mismatch), 32'(ysamp[c-W-2] != gold_mem[c-W-2]));
      else
        check_val("mismatch_idle", 32'(mismatch), 0);
      check_val("err_cnt", 32'(err_cnt), 32'((cnt > ErrMax) ? ErrMax : cnt));
      check_val("first_err_idx", 32'(first_err_idx), 32'(first));
      check_val("done", 32'(done), 32'(c >= W + N + 1));
      if (c >= W + N + 1) check_val("pass", 32'(pass), 32'(fails == 0));
      else check_val("pass_early", 32'(pass), 0);

      start = repulse && (c == 2 || c == W + 4);
      y = (c >= W && c < W + N) ? ysamp[c-W] : 10'($urandom);

      if (abort && c == W + 7) begin
        #1 reset = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("held_reset");
        reset = 1'b1;
        start = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_val("idle_rd", 32'(gold_rd), 0);
          check_val("idle_done", 32'(done), 0);
        end
        return;
      end
      @(posedge clk);
    end
    start = 1'b0;
    check_val("final_err", 32'(err_cnt), 32'((fails > ErrMax) ? ErrMax : fails));
    check_val("final_pass", 32'(pass), 32'(fails == 0));
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    @(negedge clk);
    check_val("idle_rd_por", 32'(gold_rd), 0);

    do_run(0, 1'b0, 1'b0);  // clean ramp
    do_run(1, 1'b0, 1'b0);  // single error at index 5
    do_run(2, 1'b0, 1'b0);  // all inverted, saturating count
    do_run(0, 1'b1, 1'b0);  // start from DONE after failure, with re-pulses
    for (int i = 0; i < 4; i++) do_run(3, i[0], 1'b0);
    do_run(4, 1'b0, 1'b1);  // reset during RUN at index 7
    do_run(0, 1'b0, 1'b0);  // clean run after abort

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
